// File: rtl/post_proc_unit.sv
`timescale 1ns/1ps
// post_proc_unit
// Per-lane output post-processor for the systolic-array output path.
// Three pipeline stages per beat:
//   s1: bias add (PSUM_WIDTH+1 bits, cannot overflow)
//   s2: round-half-up requantisation right shift (PSUM_WIDTH+2 bits)
//   s3: activation (none / ReLU / ReLU clamp / leaky >>>3), then
//       saturation to DATA_WIDTH with a clipped-lane count
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_layer_info          latch act_mode/out_shift/clamp_max while idle
//   act_mode, out_shift,     layer configuration
//   clamp_max
//   bias_iv, bias_id         latch per-lane biases while idle
//   in_valid/in_ready/in_data/in_last     input beat handshake
//   out_valid/out_ready/out_data/out_last output beat handshake
//   busy                     any stage holds a beat
//   sat_count                clipped lanes since last config load (sticky max)
module post_proc_unit #(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 2*DATA_WIDTH + $clog2(LANES),
    parameter int SHIFT_W    = 5,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_layer_info,
    input  logic [1:0]                  act_mode,
    input  logic [SHIFT_W-1:0]          out_shift,
    input  logic [DATA_WIDTH-1:0]       clamp_max,
    input  logic                        bias_iv,
    input  logic [LANES*DATA_WIDTH-1:0] bias_id,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*PSUM_WIDTH-1:0] in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic [CNT_W-1:0]            sat_count
);
    localparam int S1_W   = PSUM_WIDTH + 1;
    localparam int S2_W   = PSUM_WIDTH + 2;
    localparam int NSAT_W = $clog2(LANES + 1);
    localparam logic signed [S2_W-1:0] SAT_HI = S2_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [S2_W-1:0] SAT_LO = S2_W'(-(2 ** (DATA_WIDTH - 1)));

    logic [1:0]                   cfg_mode;
    logic [SHIFT_W-1:0]           cfg_shift;
    logic signed [DATA_WIDTH-1:0] cfg_clamp;
    logic signed [DATA_WIDTH-1:0] bias_r [LANES];

    logic s1_valid, s2_valid, s3_valid;
    logic s1_last, s2_last, s3_last;
    logic signed [S1_W-1:0] s1_data [LANES];
    logic signed [S1_W-1:0] s1_next [LANES];
    logic signed [S2_W-1:0] s2_data [LANES];
    logic signed [S2_W-1:0] s2_next [LANES];
    logic [DATA_WIDTH-1:0]  s3_data [LANES];
    logic [DATA_WIDTH-1:0]  s3_next [LANES];
    logic [NSAT_W-1:0]      s3_nsat, nsat_next;
    logic s3_ready, s2_ready;
    logic [CNT_W:0]         sat_sum;

    // A stage can take a new beat when it is empty or its beat moves on.
    assign s3_ready  = !s3_valid || out_ready;
    assign s2_ready  = !s2_valid || s3_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign busy      = s1_valid | s2_valid | s3_valid;
    assign out_valid = s3_valid;
    assign out_last  = s3_last;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            s1_next[l] = S1_W'($signed(in_data[l*PSUM_WIDTH +: PSUM_WIDTH])) + S1_W'(bias_r[l]);
        end
    end

    logic signed [S2_W-1:0] rq_half, rq_sum;
    always_comb begin
        rq_half = '0;
        rq_sum  = '0;
        if (cfg_shift != '0) rq_half = S2_W'(1) << (cfg_shift - SHIFT_W'(1));
        for (int l = 0; l < LANES; l++) begin
            rq_sum     = S2_W'(s1_data[l]) + rq_half;
            s2_next[l] = rq_sum >>> cfg_shift;
        end
    end

    logic signed [S2_W-1:0] act_v, clamp_ext;
    always_comb begin
        act_v     = '0;
        clamp_ext = S2_W'(cfg_clamp);
        nsat_next = '0;
        for (int l = 0; l < LANES; l++) begin
            act_v = s2_data[l];
            case (cfg_mode)
                2'd1: if (act_v < 0) act_v = '0;
                2'd2: begin
                    if (act_v < 0) act_v = '0;
                    if (act_v > clamp_ext) act_v = clamp_ext;
                end
                2'd3: if (act_v < 0) act_v = act_v >>> 3;
                default: ;
            endcase
            if (act_v > SAT_HI) begin
                s3_next[l] = SAT_HI[DATA_WIDTH-1:0];
                nsat_next  = nsat_next + NSAT_W'(1);
            end else if (act_v < SAT_LO) begin
                s3_next[l] = SAT_LO[DATA_WIDTH-1:0];
                nsat_next  = nsat_next + NSAT_W'(1);
            end else begin
                s3_next[l] = act_v[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int l = 0; l < LANES; l++) out_data[l*DATA_WIDTH +: DATA_WIDTH] = s3_data[l];
    end

    assign sat_sum = {1'b0, sat_count} + (CNT_W+1)'(s3_nsat);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode  <= '0;
            cfg_shift <= '0;
            cfg_clamp <= '0;
            sat_count <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
            s3_last   <= 1'b0;
            s3_nsat   <= '0;
            for (int l = 0; l < LANES; l++) begin
                bias_r[l]  <= '0;
                s1_data[l] <= '0;
                s2_data[l] <= '0;
                s3_data[l] <= '0;
            end
        end else begin
            // Loads are only taken while idle, so they never race an output transfer.
            if (load_layer_info && !busy) begin
                cfg_mode  <= act_mode;
                cfg_shift <= out_shift;
                cfg_clamp <= clamp_max;
                sat_count <= '0;
            end else if (s3_valid && out_ready) begin
                sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
            end
            if (bias_iv && !busy) begin
                for (int l = 0; l < LANES; l++) bias_r[l] <= bias_id[l*DATA_WIDTH +: DATA_WIDTH];
            end

            // Data registers only load with a real beat so a stalled output holds steady.
            if (s3_ready) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_data <= s3_next;
                    s3_last <= s2_last;
                    s3_nsat <= nsat_next;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s2_next;
                    s2_last <= s1_last;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= s1_next;
                    s1_last <= in_last;
                end
            end
        end
    end
endmodule
